// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin AXI4 read front end sharing one AR/R pair across NCH requesters
// One transaction in flight; R beats are steered to the granted channel with zero-cycle pass-through.
module axi_rd_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 64,
  parameter int DW  = 64,
  parameter int IDW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   req_valid,
  output logic [NCH-1:0]   req_ready,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*8-1:0] req_len,
  input  logic [NCH*3-1:0] req_size,
  output logic [NCH-1:0]   rsp_valid,
  input  logic [NCH-1:0]   rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [1:0]       rsp_resp,
  output logic             rsp_last,
  output logic [IDW-1:0]   ARID,
  output logic [AW-1:0]    ARADDR,
  output logic [7:0]       ARLEN,
  output logic [2:0]       ARSIZE,
  output logic [1:0]       ARBURST,
  output logic             ARVALID,
  input  logic             ARREADY,
  input  logic [IDW-1:0]   RID,
  input  logic [DW-1:0]    RDATA,
  input  logic [1:0]       RRESP,
  input  logic             RLAST,
  input  logic             RVALID,
  output logic             RREADY,
  output logic             busy,
  output logic             proto_err
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic [PW-1:0] rr;
  logic [PW-1:0] gid;
  logic [PW-1:0] grant;
  logic          found;
  logic [AW-1:0] addr_sel;
  logic [7:0]    len_sel;
  logic [2:0]    size_sel;
  logic          rready_sel;
  logic [8:0]    beat_cnt;
  logic          r_hs;

  // Lowest-index request overall, then overridden by the lowest index at or above rr (wrap-around search).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant = PW'(i);
        found = 1'b1;
      end
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_valid[i] && (PW'(i) >= rr)) grant = PW'(i);
    end
  end

  always_comb begin
    addr_sel   = '0;
    len_sel    = '0;
    size_sel   = '0;
    rready_sel = 1'b0;
    req_ready  = '0;
    rsp_valid  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == PW'(i)) begin
        addr_sel = req_addr[i*AW +: AW];
        len_sel  = req_len[i*8 +: 8];
        size_sel = req_size[i*3 +: 3];
      end
      if (gid == PW'(i)) rready_sel = rsp_ready[i];
      req_ready[i] = (state == IDLE) && found && (grant == PW'(i));
      rsp_valid[i] = (state == DATA) && RVALID && (gid == PW'(i));
    end
  end

  assign RREADY   = (state == DATA) && rready_sel;
  assign r_hs     = RVALID && RREADY;
  assign rsp_data = RDATA;
  assign rsp_resp = RRESP;
  assign rsp_last = RLAST;
  assign ARBURST  = 2'b01;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr        <= '0;
      gid       <= '0;
      ARID      <= '0;
      ARADDR    <= '0;
      ARLEN     <= '0;
      ARSIZE    <= '0;
      ARVALID   <= 1'b0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gid      <= grant;
            ARID     <= IDW'(grant);
            ARADDR   <= addr_sel;
            ARLEN    <= len_sel;
            ARSIZE   <= size_sel;
            ARVALID  <= 1'b1;
            beat_cnt <= '0;
            rr       <= (grant == PW'(NCH - 1)) ? '0 : grant + PW'(1);
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            // ARID/ARLEN still hold this transaction's id and length, so they double as the check reference.
            if ((RID != ARID) ||
                (RLAST && (beat_cnt != {1'b0, ARLEN})) ||
                (!RLAST && (beat_cnt == {1'b0, ARLEN})))
              proto_err <= 1'b1;
            if (RLAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scenario tests for axi_rd_arbiter against a round-robin/sticky-error reference model
module tb_axi_rd_arbiter;
  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_addr;
  logic [15:0]  req_len;
  logic [5:0]   req_size;
  logic [63:0]  rsp_data, ARADDR, RDATA;
  logic [1:0]   rsp_resp, ARBURST, RRESP;
  logic         rsp_last, ARVALID, ARREADY, RLAST, RVALID, RREADY, busy, proto_err;
  logic [3:0]   ARID, RID;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;
  bit err_m  = 1'b0;

  axi_rd_arbiter #(.NCH(2), .AW(64), .DW(64), .IDW(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // First pending channel at or after the round-robin pointer, wrapping.
  function automatic int pick(input logic [1:0] v);
    for (int i = 0; i < 2; i++) begin
      if (v[(rr_m + i) % 2]) return (rr_m + i) % 2;
    end
    return -1;
  endfunction

  task automatic set_req(input int ch, input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    req_addr[ch*64 +: 64] = a;
    req_len[ch*8 +: 8]    = l;
    req_size[ch*3 +: 3]   = s;
    req_valid[ch]         = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0; req_valid = '0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1; rr_m = 0; err_m = 1'b0;
  endtask

  // Entered just after inputs settle in a cycle where channel ch must be granted; returns one cycle after completion.
  // err_mode: 0 clean, 1 wrong RID on first beat, 2 RLAST on beat index 2.
  task automatic serve_one(input int ch, input int ar_delay, input bit bp, input int err_mode);
    logic [63:0] a, d;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  oh;
    int nbeats, b, cyc;
    a = req_addr[ch*64 +: 64]; l = req_len[ch*8 +: 8]; s = req_size[ch*3 +: 3];
    oh = '0; oh[ch] = 1'b1;
    checks++; if (req_ready !== oh) begin errors++; $display("FAIL grant: req_ready=%b exp %b", req_ready, oh); end
    @(posedge clk);
    rr_m = (ch + 1) % 2;
    @(negedge clk);
    req_valid[ch] = 1'b0; ARREADY = 1'b0;
    #1;
    for (int k = 0; k <= ar_delay; k++) begin
      checks++;
      if ({ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST} !== {1'b1, 4'(ch), a, l, s, 2'b01}) begin
        errors++; $display("FAIL ar_fields: got %b %h %h %h %h %b exp 1 %h %h %h %h 01", ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, 4'(ch), a, l, s);
      end
      checks++;
      if ({req_ready, rsp_valid, RREADY, busy} !== 6'b000001) begin
        errors++; $display("FAIL ar_quiet: req_ready=%b rsp_valid=%b RREADY=%b busy=%b exp 00 00 0 1", req_ready, rsp_valid, RREADY, busy);
      end
      if (k == ar_delay) ARREADY = 1'b1;
      @(negedge clk);
      #1;
    end
    ARREADY = 1'b0;
    checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL ar_drop: ARVALID=%b exp 0", ARVALID); end
    nbeats = (err_mode == 2) ? 3 : int'(l) + 1;
    b = 0; cyc = 0;
    while (b < nbeats && cyc < 200) begin
      d = {$urandom, $urandom};
      RVALID = ($urandom_range(0, 3) != 0); RDATA = d; RRESP = 2'($urandom);
      RID = (err_mode == 1 && b == 0) ? 4'(ch ^ 1) : 4'(ch);
      RLAST = (b == nbeats - 1);
      rsp_ready = (bp && (cyc % 2 == 1)) ? 2'b00 : 2'b11;
      if (bp) rsp_ready[ch ^ 1] = 1'($urandom);
      #1;
      checks++;
      if (rsp_valid !== (RVALID ? oh : 2'b00) || RREADY !== rsp_ready[ch]) begin
        errors++; $display("FAIL r_steer: rsp_valid=%b RREADY=%b exp %b %b", rsp_valid, RREADY, RVALID ? oh : 2'b00, rsp_ready[ch]);
      end
      checks++;
      if ({rsp_data, rsp_resp, rsp_last} !== {d, RRESP, RLAST}) begin
        errors++; $display("FAIL r_pass beat %0d: got %h %b %b exp %h %b %b", b, rsp_data, rsp_resp, rsp_last, d, RRESP, RLAST);
      end
      if (RVALID && rsp_ready[ch]) b++;
      cyc++;
      @(negedge clk);
    end
    if (err_mode != 0) err_m = 1'b1;
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    checks++; if (cyc >= 200) begin errors++; $display("FAIL r_timeout: beats=%0d exp %0d", b, nbeats); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after: busy=%b exp 0", busy); end
    checks++; if (proto_err !== err_m) begin errors++; $display("FAIL proto_err: got %b exp %b", proto_err, err_m); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '0; rsp_ready = '0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    RID = '0; RDATA = '0; RRESP = '0; req_addr = '0; req_len = '0; req_size = '0;
    #1;
    checks++;
    if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARID, RREADY, req_ready, rsp_valid, busy, proto_err} !== '0) begin
      errors++; $display("FAIL reset_state: ARVALID=%b ARADDR=%h ARLEN=%h busy=%b proto_err=%b exp all 0", ARVALID, ARADDR, ARLEN, busy, proto_err);
    end
    reset_dut();
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 64'h8000_0000, 8'd0, 3'd3);
    #1;
    serve_one(0, 0, 1'b0, 0);
  endtask

  task automatic test_contention();
    int g;
    reset_dut();
    set_req(0, {$urandom, $urandom}, 8'($urandom_range(0, 3)), 3'd3);
    set_req(1, {$urandom, $urandom}, 8'($urandom_range(0, 3)), 3'd2);
    #1;
    for (int n = 0; n < 4; n++) begin
      g = pick(req_valid);
      serve_one(g, 0, 1'b0, 0);
      set_req(g, {$urandom, $urandom}, 8'($urandom_range(0, 3)), 3'd3);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_burst_backpressure();
    @(negedge clk);
    set_req(1, 64'h0000_1000_2000_3000, 8'd3, 3'd3);
    #1;
    serve_one(1, 3, 1'b1, 0);
  endtask

  task automatic test_proto_err();
    reset_dut();
    set_req(0, 64'h40, 8'd1, 3'd3);
    #1;
    serve_one(0, 1, 1'b0, 1);
    @(negedge clk);
    set_req(1, 64'h80, 8'd2, 3'd3);
    #1;
    serve_one(1, 0, 1'b0, 0);
    reset_dut();
    set_req(0, 64'hC0, 8'd3, 3'd3);
    #1;
    serve_one(0, 0, 1'b0, 2);
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    set_req(0, 64'h100, 8'd3, 3'd3);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0; ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0; RVALID = 1'b1; RID = 4'd0; RLAST = 1'b0; RDATA = 64'h55; rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    checks++; if ({busy, rsp_valid, RREADY} !== 4'b1011) begin errors++; $display("FAIL mid_data: busy=%b rsp_valid=%b RREADY=%b exp 1 01 1", busy, rsp_valid, RREADY); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARID, RREADY, req_ready, rsp_valid, busy, proto_err} !== '0) begin
      errors++; $display("FAIL mid_reset: ARVALID=%b ARADDR=%h ARLEN=%h RREADY=%b rsp_valid=%b busy=%b exp all 0", ARVALID, ARADDR, ARLEN, RREADY, rsp_valid, busy);
    end
    RVALID = 1'b0;
    @(negedge clk);
    rstn = 1'b1; rr_m = 0; err_m = 1'b0;
    set_req(1, 64'h200, 8'd1, 3'd3);
    #1;
    serve_one(1, 0, 1'b0, 0);
    set_req(0, 64'h300, 8'd0, 3'd3);
    set_req(1, 64'h400, 8'd0, 3'd3);
    #1;
    serve_one(pick(req_valid), 0, 1'b0, 0);
    serve_one(pick(req_valid), 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int g;
    reset_dut();
    for (int n = 0; n < 30; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!req_valid[c] && $urandom_range(0, 1) == 1)
          set_req(c, {$urandom, $urandom}, 8'($urandom_range(0, 7)), 3'($urandom));
      end
      if (req_valid == 2'b00) set_req(n % 2, {$urandom, $urandom}, 8'($urandom_range(0, 7)), 3'($urandom));
      #1;
      g = pick(req_valid);
      serve_one(g, $urandom_range(0, 3), 1'($urandom), 0);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_backpressure();
    test_contention();
    test_proto_err();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Parametrised AXI4 read-master front end that lets `NCH` independent requesters share one AR/R channel pair, e.g. instruction fetch and load/store. It is the multi-channel, burst-capable successor to the single-beat fetch/load read interface in the pipeline top. It arbitrates round-robin, issues one AR transaction at a time, and steers R beats back to the granted requester. It checks beat count and RID, and holds any protocol violation in a sticky flag.

## Interface
Parameters:
- `NCH`, 2: number of requester channels (≥2).
- `AW`, 64: address width.
- `DW`, 64: data width.
- `IDW`, 4: AXI ID width; must satisfy 2^IDW ≥ NCH.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic rising-edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NCH  per-channel read request.
- `req_ready`  out  NCH  one-hot request accept.
- `req_addr`  in  NCH*AW  channel i at bits [i*AW +: AW].
- `req_len`  in  NCH*8  AXI ARLEN per channel; beats = len+1.
- `req_size`  in  NCH*3  AXI ARSIZE per channel.
- `rsp_valid`  out  NCH  one-hot beat valid to requester.
- `rsp_ready`  in  NCH  per-channel beat accept.
- `rsp_data`  out  DW  shared beat data.
- `rsp_resp`  out  2  shared beat response.
- `rsp_last`  out  1  shared last-beat flag.
- `ARID`, `ARADDR`, `ARLEN`, `ARSIZE`, `ARBURST`, `ARVALID`  out  IDW/AW/8/3/2/1  AXI read address channel.
- `ARREADY`  in  1  AXI read address ready.
- `RID`, `RDATA`, `RRESP`, `RLAST`, `RVALID`  in  IDW/DW/2/1/1  AXI read data channel.
- `RREADY`  out  1  AXI read data ready.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `proto_err`  out  1  sticky protocol-error flag.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - The grant is the first asserted `req_valid` at or after round-robin pointer `rr`, searching upward and wrapping at NCH-1.
  - `req_ready[grant]` is asserted combinationally; all other bits stay 0.
  - On the accepting edge, latch addr, len and size, set `gid = grant`, set `rr = (grant+1) mod NCH`, clear the beat counter, and go to ADDR.
  - With no `req_valid`, stay in IDLE and leave `rr` unchanged.
- ADDR:
  - `ARVALID=1`, `ARID=gid`, `ARADDR`/`ARLEN`/`ARSIZE` take the latched values, `ARBURST=2'b01` (INCR).
  - All AR fields hold stable until `ARREADY`, then go to DATA.
  - `ARVALID` drops the cycle after the handshake.
- DATA:
  - `rsp_valid[gid]=RVALID`, `RREADY=rsp_ready[gid]`; `rsp_data`, `rsp_resp` and `rsp_last` pass `RDATA`, `RRESP` and `RLAST` combinationally.
  - Each R handshake increments the 9-bit beat counter.
  - The R handshake with `RLAST=1` returns the FSM to IDLE.
- Error checks, each evaluated on an R handshake; any failure sets `proto_err` until reset:
  - `RID != gid`.
  - `RLAST=1` with beat count ≠ latched len.
  - `RLAST=0` with beat count = latched len.
- `rsp_valid` is all-zero and `RREADY=0` outside DATA.
- `req_ready` is all-zero outside IDLE.
- Requests arriving during ADDR or DATA wait and are not lost; a requester holds `req_valid` until accepted.

## Timing
- Reset values: state IDLE, `rr=0`, `ARVALID=0`, `ARADDR`/`ARLEN`/`ARSIZE`/`ARID`=0, `RREADY=0`, `req_ready=0`, `rsp_valid=0`, `busy=0`, `proto_err=0`.
- Reset assertion mid-transaction clears all state asynchronously and abandons the transaction; the slave is reset in the same domain.
- Latency:
  - Request accept at edge t gives `ARVALID` high in cycle t+1.
  - R beats pass through in zero cycles.
  - The last beat handshake at edge t gives IDLE in cycle t+1, the next grant in that same cycle, and `ARVALID` in cycle t+2.
- Exactly one AXI transaction is outstanding at any time.
- Simultaneous requests follow round-robin order. After a grant to channel k, channel k has lowest priority next time.
- `rsp_ready` low stalls `RREADY`; beat data must stay valid from the slave, and no buffering is provided.

## Test plan
- Single request: NCH=2, ch0 addr=0x8000_0000, len=0, `ARREADY` tied high, one beat 0x1122334455667788 with RLAST and RID=0 -> `ARVALID` one cycle after accept; `rsp_valid=2'b01` carries the data; `proto_err=0`; IDLE afterwards.
- Contention: ch0 and ch1 request together, repeated 4 times -> grant sequence 0,1,0,1; `ARID` matches the grant each time.
- Burst with backpressure: len=3, `ARREADY` delayed 3 cycles, `rsp_ready` toggling every cycle -> AR fields stable while waiting; exactly 4 beats delivered in order; `RREADY` mirrors `rsp_ready`.
- Protocol errors: RID=1 while gid=0 -> `proto_err`=1 and sticky. Separately, RLAST on beat 2 of len=3 -> `proto_err`=1.
- Reset mid-burst: `rstn` low during DATA after beat 1 -> all outputs reach their reset values immediately; after release, a new ch1 request completes normally with `rr=0`.
